// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU divide/modulo unit.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int ALU32_W   = 32;
    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/alu_div_unit_if.sv
// Operand/result handshake bundle between the execute stage and the divider.
interface alu_div_unit_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_32;
    logic             is_mod;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output is_32,
        output is_mod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  is_32,
        input  is_mod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );

endinterface

// File: rtl/alu_div_unit_sub_borrow_stage.sv
// Ripple subtractor a - b = a + ~b + 1; borrow is the inverted carry-out.
module sub_borrow_stage #(
    parameter int W = 65
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W-1:0] nb;
    logic         carry;

    assign nb = ~b;

    always_comb begin
        diff  = '0;
        carry = 1'b1;
        for (int i = 0; i < W; i++) begin
            diff[i] = a[i] ^ nb[i] ^ carry;
            carry   = (a[i] & nb[i]) | (carry & (a[i] ^ nb[i]));
        end
        borrow = ~carry;
    end

endmodule

// File: rtl/alu_div_unit.sv
// Iterative restoring unsigned divider/modulo for eBPF DIV/MOD (64 and 32 bit).
module alu_div_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic           clk,
    input logic           rst,
    alu_div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] res;
    logic             is_32_q;
    logic             is_mod_q;
    logic             out_vld;

    logic             accept;
    logic             shift_in;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             unused_diff_msb;
    logic [WIDTH-1:0] in_mask;
    logic [WIDTH-1:0] dd_m;
    logic [WIDTH-1:0] dv_m;
    logic [WIDTH-1:0] res_nxt;

    assign accept = bus.in_valid && (state == IDLE);

    // ALU32 operands are masked once here so the datapath never sees upper bits
    always_comb begin
        in_mask = '1;
        if (bus.is_32) begin
            in_mask = {{(WIDTH-ALU32_W){1'b0}}, {ALU32_W{1'b1}}};
        end
        dd_m = bus.dividend & in_mask;
        dv_m = bus.divisor & in_mask;
    end

    assign shift_in = is_32_q ? q[ALU32_W-1] : q[WIDTH-1];
    assign r_sh     = {r, shift_in};

    sub_borrow_stage #(
        .W (WIDTH+1)
    ) u_sub (
        .a      (r_sh),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    // a non-borrowing subtract leaves a remainder below the divisor
    assign unused_diff_msb = diff[WIDTH];

    always_comb begin
        res_nxt = is_mod_q ? r : q;
        if (is_32_q) begin
            res_nxt[WIDTH-1:ALU32_W] = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (dv_m == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_vld && bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            r        <= '0;
            q        <= '0;
            dvs      <= '0;
            is_32_q  <= 1'b0;
            is_mod_q <= 1'b0;
        end else if (accept) begin
            is_32_q  <= bus.is_32;
            is_mod_q <= bus.is_mod;
            dvs      <= dv_m;
            cnt      <= bus.is_32 ? CNT_W'(ALU32_W-1) : CNT_W'(WIDTH-1);
            // zero divisor skips RUN: quotient 0, remainder = dividend
            if (dv_m == '0) begin
                q <= '0;
                r <= dd_m;
            end else begin
                q <= dd_m;
                r <= '0;
            end
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            if (!borrow) begin
                r <= diff[WIDTH-1:0];
                q <= {q[WIDTH-2:0], 1'b1};
            end else begin
                r <= r_sh[WIDTH-1:0];
                q <= {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            res     <= '0;
        end else if (state == DONE && !out_vld) begin
            out_vld <= 1'b1;
            res     <= res_nxt;
        end else if (out_vld && bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_vld;
    assign bus.result    = res;

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed-vector bench for alu_div_unit: results, latency, backpressure, reset.
module tb_alu_div_unit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    always #5 clk = ~clk;

    alu_div_unit_if bus ();

    alu_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [63:0] dd, input logic [63:0] dv,
                         input logic i32, input logic im);
        @(negedge clk);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.is_32    = i32;
        bus.is_mod   = im;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ov_clr"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_ir_set"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic op(input string tag, input logic [63:0] dd, input logic [63:0] dv,
                      input logic i32, input logic im,
                      input logic [63:0] exp, input int exp_lat);
        int l;
        start(dd, dv, i32, im);
        wait_done(l);
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        chk(tag, bus.result, exp);
        handshake(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.is_32     = 1'b0;
        bus.is_mod    = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        rst = 1'b0;

        op("div64_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 65);
        op("mod64_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 65);

        op("div32", 64'hFFFF_FFFF_0000_000A, 64'h1234_0000_0000_0003, 1'b1, 1'b0, 64'd3, 33);
        op("mod32", 64'hFFFF_FFFF_0000_000A, 64'h1234_0000_0000_0003, 1'b1, 1'b1, 64'd1, 33);

        op("div0_div", 64'd5, 64'd0, 1'b0, 1'b0, 64'd0, 1);
        op("div0_mod", 64'd5, 64'd0, 1'b0, 1'b1, 64'd5, 1);
        op("div0_mod32", 64'h0000_00AB_0000_0005, 64'd0, 1'b1, 1'b1, 64'd5, 1);

        op("max_div1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 65);
        op("max_divmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0,
           64'd1, 65);
        op("max_modmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
           64'd0, 65);
        op("div_3_10", 64'd3, 64'd10, 1'b0, 1'b0, 64'd0, 65);
        op("mod_3_10", 64'd3, 64'd10, 1'b0, 1'b1, 64'd3, 65);

        // backpressure: hold out_ready low, poke in_valid
        start(64'd100, 64'd7, 1'b0, 1'b0);
        wait_done(lat);
        chk("bp_lat", 64'(lat), 64'd65);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.dividend = 64'(i + 40);
            bus.divisor  = 64'd3;
            bus.is_mod   = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_result", bus.result, 64'd14);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        handshake("bp");

        // reset in the middle of RUN
        start(64'd100, 64'd7, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_ov", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ir", 64'(bus.in_ready), 64'd1);
        chk("mid_rst_res", bus.result, 64'd0);
        op("post_rst_9_2", 64'd9, 64'd2, 1'b0, 1'b0, 64'd4, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
